// File: rtl/ita_package.sv
// -----------------------------------------------------------------------------
// ita_package
//   Shared widths and types for the ITA datapath.
//   WI                   : requantised element width (signed)
//   GELU_CONSTANTS_WIDTH : width of the i-GELU constants one/b/c (signed)
//   GELU_OUT_WIDTH       : i-GELU / activation output element width (signed)
//   act_mode_e           : per-beat activation select for ita_activation_unit
// -----------------------------------------------------------------------------
package ita_package;

   localparam int unsigned WI                   = 8;
   localparam int unsigned GELU_CONSTANTS_WIDTH = 16;
   localparam int unsigned GELU_OUT_WIDTH       = 26;

   typedef logic signed [WI-1:0]                   requant_t;
   typedef logic signed [GELU_CONSTANTS_WIDTH-1:0] gelu_const_t;
   typedef logic signed [GELU_OUT_WIDTH-1:0]       gelu_out_t;

   // Encoding 3 is reserved and behaves as identity.
   typedef enum logic [1:0] {
      ACT_IDENT = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_GELU  = 2'd2,
      ACT_RSVD  = 2'd3
   } act_mode_e;

endpackage

// File: rtl/ita_activation_lane.sv
// -----------------------------------------------------------------------------
// ita_activation_lane
//   One lane of the activation datapath: two register stages, no handshake.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     en1_i        : load stage 1 (input beat accepted)
//     en2_i        : load stage 2 (stage-1 beat advances)
//     b_i          : i-GELU b of the incoming beat (used before stage 1)
//     mode_i       : activation mode of the beat held in stage 1
//     one_i, c_i   : i-GELU one/c of the beat held in stage 1
//     x_i          : signed input element
//     y_o          : registered signed output element (stage 2)
// -----------------------------------------------------------------------------
module ita_activation_lane
   import ita_package::*;
#(
   parameter int unsigned WI = ita_package::WI,
   parameter int unsigned CW = ita_package::GELU_CONSTANTS_WIDTH,
   parameter int unsigned OW = ita_package::GELU_OUT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en1_i,
   input  logic                 en2_i,
   input  logic signed [CW-1:0] b_i,
   input  act_mode_e            mode_i,
   input  logic signed [CW-1:0] one_i,
   input  logic signed [CW-1:0] c_i,
   input  logic signed [WI-1:0] x_i,
   output logic signed [OW-1:0] y_o
);

   // ---------------- stage 0: clipped square ----------------
   logic signed [CW-1:0] x_c;
   logic signed [CW-1:0] abs_x;
   logic signed [CW-1:0] neg_b;
   logic signed [CW-1:0] a_clip;
   logic signed [CW-1:0] p;
   logic signed [OW-1:0] p_w;
   logic signed [OW-1:0] sq;

   // x is widened before negation so that -(-2^(WI-1)) is representable.
   assign x_c    = {{(CW-WI){x_i[WI-1]}}, x_i};
   assign abs_x  = x_i[WI-1] ? -x_c : x_c;
   assign neg_b  = -b_i;
   assign a_clip = (abs_x < neg_b) ? abs_x : neg_b;
   assign p      = a_clip + b_i;
   assign p_w    = {{(OW-CW){p[CW-1]}}, p};
   assign sq     = p_w * p_w;

   // ---------------- stage 1 registers ----------------
   logic signed [WI-1:0] x1;
   logic signed [OW-1:0] sq1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its inputs regardless of statement order.
   // NOTE: the datapath registers are reset too, so data_o reads zero right
   // after reset and no stale beat can leak out of a flushed pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x1  <= '0;
         sq1 <= '0;
      end else if (en1_i) begin
         x1  <= x_i;
         sq1 <= sq;
      end
   end

   // ---------------- stage 1 -> 2: polynomial and mode select ----------------
   logic signed [OW-1:0] x1_w;
   logic signed [OW-1:0] c_w;
   logic signed [OW-1:0] one_w;
   logic signed [OW-1:0] l_v;
   logic signed [OW-1:0] e_v;
   logic signed [OW-1:0] s_v;
   logic signed [OW-1:0] g_v;
   logic signed [OW-1:0] y_nxt;

   assign x1_w  = {{(OW-WI){x1[WI-1]}}, x1};
   assign c_w   = {{(OW-CW){c_i[CW-1]}}, c_i};
   assign one_w = {{(OW-CW){one_i[CW-1]}}, one_i};
   assign l_v   = sq1 + c_w;
   assign e_v   = x1[WI-1] ? -l_v : l_v;
   assign s_v   = e_v + one_w;
   assign g_v   = x1_w * s_v;

   // NOTE: y_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      y_nxt = x1_w;
      unique case (mode_i)
         ACT_GELU: y_nxt = g_v;
         ACT_RELU: y_nxt = x1[WI-1] ? '0 : x1_w;
         default:  y_nxt = x1_w;
      endcase
   end

   // ---------------- stage 2 register ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         y_o <= '0;
      end else if (en2_i) begin
         y_o <= y_nxt;
      end
   end

endmodule

// File: rtl/ita_activation_unit.sv
// -----------------------------------------------------------------------------
// ita_activation_unit
//   Elastic N_LANES-wide activation stage (identity / ReLU / integer i-GELU)
//   with valid/ready handshake, two register stages and a last sideband.
//   Ports:
//     clk_i, rst_i          : clock, synchronous active-high reset
//     mode_i                : act_mode_e of the incoming beat
//     one_i, b_i, c_i       : i-GELU constants, sampled with each beat
//     in_valid_i/in_ready_o : input handshake
//     in_last_i             : sideband, delivered on out_last_o
//     data_i                : lane k = data_i[k*WI +: WI]
//     out_valid_o/out_ready_i : output handshake
//     out_last_o            : delayed in_last_i
//     data_o                : lane k = data_o[k*OW +: OW]
// -----------------------------------------------------------------------------
module ita_activation_unit
   import ita_package::*;
#(
   parameter int unsigned N_LANES = 16,
   parameter int unsigned WI      = ita_package::WI,
   parameter int unsigned CW      = ita_package::GELU_CONSTANTS_WIDTH,
   parameter int unsigned OW      = ita_package::GELU_OUT_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [1:0]              mode_i,
   input  logic signed [CW-1:0]    one_i,
   input  logic signed [CW-1:0]    b_i,
   input  logic signed [CW-1:0]    c_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic                    in_last_i,
   input  logic [N_LANES*WI-1:0]   data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    out_last_o,
   output logic [N_LANES*OW-1:0]   data_o
);

   logic                 v1;
   logic                 v2;
   logic                 last1;
   logic                 last2;
   act_mode_e            mode1;
   logic signed [CW-1:0] one1;
   logic signed [CW-1:0] c1;
   logic                 en1;
   logic                 en2;
   logic                 ld1;
   logic                 ld2;

   // A stage may load when it is empty or its content moves on this cycle;
   // the ready path is combinational so a full pipe streams without bubbles.
   assign en2        = !v2 || out_ready_i;
   assign en1        = !v1 || en2;
   assign in_ready_o = en1;

   // Data registers only load real beats; idle cycles leave them untouched.
   assign ld1 = en1 && in_valid_i;
   assign ld2 = en2 && v1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         last1 <= 1'b0;
         last2 <= 1'b0;
         mode1 <= ACT_IDENT;
         one1  <= '0;
         c1    <= '0;
      end else begin
         if (en1) begin
            v1 <= in_valid_i;
         end
         if (ld1) begin
            last1 <= in_last_i;
            mode1 <= act_mode_e'(mode_i);
            one1  <= one_i;
            c1    <= c_i;
         end
         if (en2) begin
            v2 <= v1;
         end
         if (ld2) begin
            last2 <= last1;
         end
      end
   end

   assign out_valid_o = v2;
   assign out_last_o  = last2;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      ita_activation_lane #(
         .WI (WI),
         .CW (CW),
         .OW (OW)
      ) u_lane (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .en1_i  (ld1),
         .en2_i  (ld2),
         .b_i    (b_i),
         .mode_i (mode1),
         .one_i  (one1),
         .c_i    (c1),
         .x_i    (data_i[k*WI +: WI]),
         .y_o    (data_o[k*OW +: OW])
      );
   end

endmodule
